// File: rtl/apb_requester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_requester_pkg
// Description : Shared types for the APB3 command requester.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_requester_pkg;

    typedef enum logic [1:0] {
        APB_RSP_OK      = 2'd0,
        APB_RSP_SLVERR  = 2'd1,
        APB_RSP_TIMEOUT = 2'd2
    } apb_rsp_status_t;

    typedef enum logic [1:0] {
        REQ_IDLE   = 2'd0,
        REQ_SETUP  = 2'd1,
        REQ_ACCESS = 2'd2,
        REQ_RESP   = 2'd3
    } apb_req_state_t;

    // Watchdog counter width; a disabled watchdog still needs a legal width.
    function automatic int unsigned wd_width(input int unsigned timeout_cycles);
        return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_if.sv
`default_nettype none
// ============================================================================
// Module      : APB
// Description : APB3 signal bundle with requester and completer views.
// Revision    : 1.0 - initial release
// ============================================================================
interface APB #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport requester (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport completer (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_cmd_requester.sv
`default_nettype none
// ============================================================================
// Module      : apb_cmd_requester
// Description : Valid/ready command stream to single APB3 transfers, with a
//               response stream and a PREADY watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_cmd_requester
    import apb_requester_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_status,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);

    APB #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_apb ();

    apb_req_state_t        r_state;
    apb_req_state_t        w_state_nxt;
    logic                  w_cmd_fire;
    logic                  w_done;
    logic                  w_timeout;
    logic                  w_wd_expired;

    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    apb_rsp_status_t       r_rsp_status;

    assign u_apb.psel    = r_psel;
    assign u_apb.penable = r_penable;
    assign u_apb.pwrite  = r_pwrite;
    assign u_apb.paddr   = r_paddr;
    assign u_apb.pwdata  = r_pwdata;
    assign u_apb.prdata  = prdata;
    assign u_apb.pready  = pready;
    assign u_apb.pslverr = pslverr;

    assign psel       = u_apb.psel;
    assign penable    = u_apb.penable;
    assign pwrite     = u_apb.pwrite;
    assign paddr      = u_apb.paddr;
    assign pwdata     = u_apb.pwdata;
    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_status = r_rsp_status;

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_fire  = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            REQ_IDLE: begin
                if (cmd_valid) begin
                    w_cmd_fire  = 1'b1;
                    w_state_nxt = REQ_SETUP;
                end
            end
            REQ_SETUP: begin
                w_state_nxt = REQ_ACCESS;
            end
            REQ_ACCESS: begin
                // A completion in the expiry cycle takes priority over the abort.
                if (u_apb.pready) begin
                    w_done      = 1'b1;
                    w_state_nxt = REQ_RESP;
                end else if (w_wd_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = REQ_RESP;
                end
            end
            REQ_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = REQ_IDLE;
                end
            end
            default: begin
                w_state_nxt = REQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state     <= REQ_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= (w_state_nxt == REQ_SETUP) || (w_state_nxt == REQ_ACCESS);
            r_penable   <= (w_state_nxt == REQ_ACCESS);
            r_cmd_ready <= (w_state_nxt == REQ_IDLE);
            r_rsp_valid <= (w_state_nxt == REQ_RESP);
        end
    end

    // Transfer attributes only change on command acceptance, so they hold across the transfer.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (w_cmd_fire) begin
            r_pwrite <= cmd_write;
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_wdata;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_rsp_rdata  <= '0;
            r_rsp_status <= APB_RSP_OK;
        end else if (w_done) begin
            r_rsp_rdata  <= r_pwrite ? '0 : u_apb.prdata;
            r_rsp_status <= u_apb.pslverr ? APB_RSP_SLVERR : APB_RSP_OK;
        end else if (w_timeout) begin
            r_rsp_rdata  <= '0;
            r_rsp_status <= APB_RSP_TIMEOUT;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_watchdog
            localparam int unsigned c_WD_W = wd_width(TIMEOUT_CYCLES);
            localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES - 1);

            logic [c_WD_W-1:0] r_wd_cnt;

            // Held at zero outside ACCESS, so every transfer starts counting from zero.
            always_ff @(posedge pclk or negedge preset_n) begin
                if (!preset_n) begin
                    r_wd_cnt <= '0;
                end else if (r_state != REQ_ACCESS) begin
                    r_wd_cnt <= '0;
                end else if (!u_apb.pready && (r_wd_cnt != c_WD_LIMIT)) begin
                    r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
                end
            end

            assign w_wd_expired = (r_wd_cnt == c_WD_LIMIT);
        end else begin : g_no_watchdog
            assign w_wd_expired = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_cmd_requester
// Description : Self-checking bench: directed vector table, randomized
//               transfers against a reference model, and an async reset case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_requester;

    localparam int c_TIMEOUT = 4;

    logic        pclk;
    logic        preset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    apb_cmd_requester #(
        .ADDR_WIDTH     (16),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .pclk       (pclk),
        .preset_n   (preset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_status (rsp_status),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rd;
        logic        err;
        int          hold;
        logic [1:0]  exp_status;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response rules: the completer answers after 'waits' wait states unless
    // the watchdog allowance of c_TIMEOUT ACCESS cycles is used up first.
    function automatic vec_t ref_model(input vec_t v);
        vec_t r = v;
        if (v.waits < c_TIMEOUT) begin
            r.exp_status = v.err ? 2'd1 : 2'd0;
            r.exp_rdata  = v.wr ? 32'h0 : v.rd;
            r.exp_lat    = 3 + v.waits;
        end else begin
            r.exp_status = 2'd2;
            r.exp_rdata  = 32'h0;
            r.exp_lat    = 2 + c_TIMEOUT;
        end
        return r;
    endfunction

    // Entered and left just after a falling edge.
    task automatic txn(input vec_t v);
        int          cyc;
        int          lat;
        int          acc;
        bit          attr_ok;
        bit          hold_ok;
        logic [31:0] h_rdata;
        logic [1:0]  h_status;

        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        pready    = 1'($urandom);
        pslverr   = 1'($urandom);
        prdata    = $urandom;
        cyc = 0;
        while (!cmd_ready && cyc < 20) begin
            @(negedge pclk);
            cyc++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_bound", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 16'($urandom);
        cmd_wdata = $urandom;
        lat       = 1;
        acc       = 0;
        attr_ok   = 1'b1;
        check("setup_psel", 32'(psel), 32'd1);
        check("setup_penable", 32'(penable), 32'd0);

        while (!rsp_valid && lat < 30) begin
            if (psel && (paddr !== v.addr || pwrite !== v.wr || pwdata !== v.wdata))
                attr_ok = 1'b0;
            if (psel && penable) begin
                pready  = (acc == v.waits);
                prdata  = v.rd;
                pslverr = v.err;
                acc++;
            end else begin
                pready  = 1'($urandom);
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
            @(negedge pclk);
            lat++;
        end
        check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        check("attr_stable", 32'(attr_ok), 32'd1);
        check("rsp_latency", 32'(lat), 32'(v.exp_lat));
        check("access_cycles", 32'(acc), 32'(v.exp_lat - 2));
        check("rsp_status", 32'(rsp_status), 32'(v.exp_status));
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("resp_psel_low", 32'(psel | penable), 32'd0);

        // Hold the response with a competing command and late completer noise.
        h_rdata   = rsp_rdata;
        h_status  = rsp_status;
        hold_ok   = 1'b1;
        cmd_valid = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            rsp_ready = 1'b0;
            pready    = 1'b1;
            pslverr   = 1'($urandom);
            prdata    = $urandom;
            @(negedge pclk);
            if (!rsp_valid || rsp_rdata !== h_rdata || rsp_status !== h_status
                || cmd_ready || psel || penable)
                hold_ok = 1'b0;
        end
        if (v.hold > 0) check("rsp_hold_stable", 32'(hold_ok), 32'd1);
        rsp_ready = 1'b1;
        pready    = 1'b0;
        @(negedge pclk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rsp_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rsp_psel", 32'(psel), 32'd0);
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        preset_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;

        //           wr    addr      wdata         waits rd            err   hold st     rdata         lat
        tbl[0] = '{1'b1, 16'h0004, 32'hDEADBEEF, 0,    32'hAAAA5555, 1'b0, 0,   2'd0, 32'h0,        3};
        tbl[1] = '{1'b0, 16'h0010, 32'h0,        3,    32'h12345678, 1'b0, 1,   2'd0, 32'h12345678, 6};
        tbl[2] = '{1'b1, 16'h0020, 32'h00000001, 0,    32'h55555555, 1'b1, 3,   2'd1, 32'h0,        3};
        tbl[3] = '{1'b0, 16'h0030, 32'h0,        1000, 32'hFFFFFFFF, 1'b1, 4,   2'd2, 32'h0,        6};
        tbl[4] = '{1'b0, 16'h0044, 32'h0,        2,    32'hCAFEF00D, 1'b0, 10,  2'd0, 32'hCAFEF00D, 5};
        tbl[5] = '{1'b0, 16'h0050, 32'h0,        1,    32'h0BADF00D, 1'b1, 0,   2'd1, 32'h0BADF00D, 4};
        tbl[6] = '{1'b1, 16'hFFFC, 32'h13579BDF, 4,    32'h2468ACE0, 1'b0, 2,   2'd2, 32'h0,        6};

        repeat (2) @(negedge pclk);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_pwrite", 32'(pwrite), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_paddr", 32'(paddr), 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_status", 32'(rsp_status), 32'd0);
        preset_n = 1'b1;
        @(negedge pclk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) txn(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            rv.wr    = 1'($urandom);
            rv.addr  = 16'($urandom);
            rv.wdata = $urandom;
            rv.waits = int'($urandom_range(0, 5));
            rv.rd    = $urandom;
            rv.err   = 1'($urandom);
            rv.hold  = int'($urandom_range(0, 3));
            txn(ref_model(rv));
        end

        // Asynchronous reset in the middle of an ACCESS phase.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0060;
        pready    = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        check("pre_reset_access", 32'({psel, penable}), 32'd3);
        #2;
        preset_n = 1'b0;
        #1;
        check("async_rst_psel", 32'(psel), 32'd0);
        check("async_rst_penable", 32'(penable), 32'd0);
        check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge pclk);
        preset_n  = 1'b1;
        pready    = 1'b1;
        pslverr   = 1'b1;
        rsp_ready = 1'b0;
        begin
            bit quiet_ok = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(negedge pclk);
                if (rsp_valid || psel || !cmd_ready) quiet_ok = 1'b0;
            end
            check("post_reset_quiet", 32'(quiet_ok), 32'd1);
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        rv = '{1'b0, 16'h0070, 32'h0, 0, 32'h89ABCDEF, 1'b0, 0, 2'd0, 32'h0, 0};
        txn(ref_model(rv));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
